// File: rtl/barrel_shifter_arbiter_pkg.sv
// Shared types and helpers for barrel_shifter_arbiter.
// Holds the output FSM state enum and the pointer wrap helper.
package barrel_shifter_arbiter_pkg;

  // Output register stage: StEmpty means no result is held, StFull means result_valid is high.
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/barrel_shifter_right.sv
// Combinational logical right shifter with a selectable fill bit.
// The vacated upper bits are filled with pad_value.
module barrel_shifter_right
  import barrel_shifter_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   pad_value,
  output logic [DATA_WIDTH-1:0]  result
);

  logic [DATA_WIDTH-1:0] stage;

  // Logarithmic shifter: stage s moves by 2**s when shift[s] is set.
  always_comb begin
    stage = data;
    for (int s = 0; s < SHIFT_WIDTH; s++) begin
      if (shift[s]) begin
        stage = (stage >> (1 << s)) |
                (pad_value ? ~({DATA_WIDTH{1'b1}} >> (1 << s)) : '0);
      end
    end
    result = stage;
  end

endmodule

// File: rtl/barrel_shifter_arbiter.sv
// Arbitrated barrel shifter: grants one requester per cycle, shifts its operand
// right with pad fill, and registers the result behind a valid/ready handshake.
// Define BARREL_SHIFTER_ARBITER_ROUND_ROBIN_EN for round-robin grant; otherwise
// fixed priority (lowest valid index wins).
module barrel_shifter_arbiter
  import barrel_shifter_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int unsigned REQUESTERS  = 4,
  parameter int unsigned ID_WIDTH    = $clog2(REQUESTERS)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [REQUESTERS-1:0]             request_valid,
  output logic [REQUESTERS-1:0]             request_ready,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]  request_data,
  input  logic [REQUESTERS*SHIFT_WIDTH-1:0] request_shift,
  input  logic [REQUESTERS-1:0]             request_pad_value,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic [DATA_WIDTH-1:0]             result_data,
  output logic [ID_WIDTH-1:0]               result_id
);

  out_state_e              state_q, state_d;
  logic [REQUESTERS-1:0]   grant;
  logic [ID_WIDTH-1:0]     grant_id;
  logic                    found;
  logic                    can_accept;
  logic                    transfer;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [SHIFT_WIDTH-1:0]  sel_shift;
  logic                    sel_pad;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [ID_WIDTH-1:0]     id_q;

`ifdef BARREL_SHIFTER_ARBITER_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  // Round-robin search: indices at or above the pointer first, then wrap to the low ones.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!found && request_valid[i] && (ID_WIDTH'(i) >= ptr_q)) begin
        found    = 1'b1;
        grant_id = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!found && request_valid[i]) begin
        found    = 1'b1;
        grant_id = ID_WIDTH'(i);
      end
    end
  end

  // Next pointer is one past the granted requester.
  always_comb begin
    ptr_d = ID_WIDTH'(wrap_inc(32'(grant_id), REQUESTERS));
  end

  // Pointer moves only on a transfer, so idle cycles leave arbitration untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (transfer) begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!found && request_valid[i]) begin
        found    = 1'b1;
        grant_id = ID_WIDTH'(i);
      end
    end
  end
`endif

  // One-hot grant vector and operand select for the granted requester.
  always_comb begin
    grant     = '0;
    sel_data  = '0;
    sel_shift = '0;
    sel_pad   = 1'b0;
    if (found) begin
      grant[grant_id] = 1'b1;
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant[i]) begin
        sel_data  = request_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_shift = request_shift[i*SHIFT_WIDTH +: SHIFT_WIDTH];
        sel_pad   = request_pad_value[i];
      end
    end
  end

  // Accept when empty, or when full and the held result drains this cycle.
  // Ready derives from request_valid and local state only, never from other readies.
  always_comb begin
    can_accept    = (state_q == StEmpty) || result_ready;
    request_ready = grant & {REQUESTERS{can_accept && !reset}};
    transfer      = |request_ready;
  end

  barrel_shifter_right #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shifter (
    .data      (sel_data),
    .shift     (sel_shift),
    .pad_value (sel_pad),
    .result    (shifted)
  );

  // Output FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (transfer) state_d = StFull;
      StFull:  if (result_ready && !transfer) state_d = StEmpty;
    endcase
  end

  // State and result register; reset discards any held result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        data_q <= shifted;
        id_q   <= grant_id;
      end
    end
  end

  assign result_valid = (state_q == StFull);
  assign result_data  = data_q;
  assign result_id    = id_q;

endmodule

// File: tb/tb_barrel_shifter_arbiter.sv
// Scoreboard bench for barrel_shifter_arbiter (DATA_WIDTH=8, REQUESTERS=4).
// Honours BARREL_SHIFTER_ARBITER_ROUND_ROBIN_EN to pick the reference grant rule.
module tb_barrel_shifter_arbiter;

  localparam int DW = 8;
  localparam int SW = 3;
  localparam int NR = 4;
  localparam int IW = 2;
`ifdef BARREL_SHIFTER_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    request_valid = '0;
  logic [NR-1:0]    request_ready;
  logic [NR*DW-1:0] request_data = '0;
  logic [NR*SW-1:0] request_shift = '0;
  logic [NR-1:0]    request_pad_value = '0;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic [DW-1:0]    result_data;
  logic [IW-1:0]    result_id;

  typedef struct {
    int data;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_full = 0;
  int   m_ptr  = 0;

  always #5 clock = ~clock;

  barrel_shifter_arbiter #(
    .DATA_WIDTH  (DW),
    .SHIFT_WIDTH (SW),
    .REQUESTERS  (NR),
    .ID_WIDTH    (IW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .request_valid     (request_valid),
    .request_ready     (request_ready),
    .request_data      (request_data),
    .request_shift     (request_shift),
    .request_pad_value (request_pad_value),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .result_data       (result_data),
    .result_id         (result_id)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift: plain divide-by-shift then set the top bits one at a time.
  function automatic int model_shift(int d, int s, bit p);
    int r;
    r = d >> s;
    if (p) for (int b = DW - s; b < DW; b++) r = r | (1 << b);
    return r;
  endfunction

  function automatic int model_grant(logic [NR-1:0] v, int ptr);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = RR ? (ptr + k) % NR : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(int i, int d, int s, bit p);
    request_data[i*DW +: DW]  = d[DW-1:0];
    request_shift[i*SW +: SW] = s[SW-1:0];
    request_pad_value[i]      = p;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: predicts request_ready and result_valid, pushes accepted results.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("ready_in_reset", 32'(request_ready), 32'h0);
        exp_q.delete();
        m_full = 0;
        m_ptr  = 0;
      end else begin
        int g;
        bit can;
        int exp_ready;
        check("result_valid", 32'(result_valid), 32'(m_full));
        g         = model_grant(request_valid, m_ptr);
        can       = (m_full == 0) || result_ready;
        exp_ready = (g >= 0 && can) ? (1 << g) : 0;
        check("request_ready", 32'(request_ready), 32'(exp_ready));
        if (exp_ready != 0) begin
          exp_t e;
          e.data = model_shift(int'(request_data[g*DW +: DW]), int'(request_shift[g*SW +: SW]),
                               request_pad_value[g]);
          e.id   = g;
          exp_q.push_back(e);
          m_full = 1;
          m_ptr  = (g + 1) % NR;
        end else if (result_ready) begin
          m_full = 0;
        end
      end
    end
  end

  // Monitor: compares each result as it is handed off downstream.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && result_valid === 1'b1 && result_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(result_valid), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_data", 32'(result_data), 32'(e.data));
          check("result_id", 32'(result_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    int hold_data;
    step();
    step();
    reset = 1'b0;
    check("reset_valid", 32'(result_valid), 32'h0);
    check("reset_data", 32'(result_data), 32'h0);
    check("reset_id", 32'(result_id), 32'h0);

    // Single request from requester 1.
    set_req(1, 'h80, 3, 1'b0);
    request_valid = 4'b0010;
    #3;
    check("single_ready", 32'(request_ready), 32'h2);
    step();
    check("single_valid", 32'(result_valid), 32'h1);
    check("single_data", 32'(result_data), 32'h10);
    check("single_id", 32'(result_id), 32'h1);
    request_valid = '0;
    result_ready  = 1'b1;
    step();

    // Pad fill and shift boundaries from requester 2.
    request_valid = 4'b0100;
    set_req(2, 'h0F, 2, 1'b1);
    step();
    check("pad_c3", 32'(result_data), 32'hC3);
    check("pad_c3_id", 32'(result_id), 32'h2);
    set_req(2, 'h80, 7, 1'b1);
    step();
    check("shift7_ff", 32'(result_data), 32'hFF);
    set_req(2, 'h5A, 0, 1'b1);
    step();
    check("shift0", 32'(result_data), 32'h5A);
    request_valid = '0;
    step();

    // All requesters valid, downstream always ready.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 'h96 + i, i + 1, i[0]);
    request_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      check("all_valid_id", 32'(result_id), RR ? 32'(c % NR) : 32'h0);
      check("all_valid_valid", 32'(result_valid), 32'h1);
    end

    // Backpressure holds the last result (requester 0 in both modes).
    hold_data    = model_shift('h96, 1, 1'b0);
    result_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_valid", 32'(result_valid), 32'h1);
      check("bp_data", 32'(result_data), 32'(hold_data));
      check("bp_id", 32'(result_id), 32'h0);
      check("bp_ready", 32'(request_ready), 32'h0);
    end
    request_valid = 4'b1000;
    set_req(3, 'hF0, 4, 1'b0);
    result_ready  = 1'b1;
    step();
    check("refill_id", 32'(result_id), 32'h3);
    check("refill_data", 32'(result_data), 32'h0F);
    check("refill_valid", 32'(result_valid), 32'h1);

    // Reset while full with requesters valid.
    result_ready  = 1'b0;
    request_valid = 4'b1111;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_full_valid", 32'(result_valid), 32'h0);
    check("rst_full_data", 32'(result_data), 32'h0);
    check("rst_full_id", 32'(result_id), 32'h0);
    result_ready = 1'b1;
    step();
    check("post_rst_id", 32'(result_id), 32'h0);
    check("post_rst_valid", 32'(result_valid), 32'h1);

    // Randomized traffic checked by the scoreboard.
    for (int c = 0; c < 400; c++) begin
      request_valid = NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
      end
      result_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Drain.
    request_valid = '0;
    result_ready  = 1'b1;
    for (int c = 0; c < 3; c++) step();
    @(negedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_arbiter.md
BARREL_SHIFTER_ARBITER -- requirements
Module: barrel_shifter_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter SHIFT_WIDTH, default $clog2(DATA_WIDTH), giving the shift amount width.
REQ-003 The block SHALL have parameter REQUESTERS, default 4, giving the number of requesters (at least 2).
REQ-004 The block SHALL have parameter ID_WIDTH, default $clog2(REQUESTERS), giving the result identifier width.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 request_valid  input  REQUESTERS  per-requester operation valid.
REQ-009 request_ready  output  REQUESTERS  per-requester operation accepted.
REQ-010 request_data  input  REQUESTERS*DATA_WIDTH  packed operands; requester i in slice i.
REQ-011 request_shift  input  REQUESTERS*SHIFT_WIDTH  packed right-shift amounts.
REQ-012 request_pad_value  input  REQUESTERS  per-requester pad bit.
REQ-013 result_valid  output  1  result register holds a result.
REQ-014 result_ready  input  1  downstream accepts the result.
REQ-015 result_data  output  DATA_WIDTH  shifted result.
REQ-016 result_id  output  ID_WIDTH  index of the requester that produced result_data.

Function
REQ-017 The block SHALL compute result = (data >> shift) with the vacated upper `shift` bits filled with pad_value, for shift in 0..DATA_WIDTH-1.
REQ-018 The output stage SHALL be a two-state FSM: EMPTY (result_valid=0) and FULL (result_valid=1).
REQ-019 The block SHALL be able to accept a request when in EMPTY, or when in FULL with result_ready=1 (same-cycle drain and refill).
REQ-020 Exactly one requester SHALL be granted per cycle, and only among those with request_valid=1; request_ready SHALL be one-hot or zero.
REQ-021 request_ready[i] SHALL be 1 only when requester i is granted and the block can accept; it SHALL NOT depend on request_ready of other requesters.
REQ-022 A transfer SHALL occur when request_valid[i] and request_ready[i] are both 1; result_data and result_id SHALL be registered on that edge (latency one cycle).
REQ-023 FSM transitions SHALL be: EMPTY→FULL on a transfer; FULL→EMPTY on result_ready with no transfer; FULL→FULL on result_ready with a transfer, or on result_ready=0.
REQ-024 While FULL and result_ready=0, result_data and result_id SHALL hold stable and all request_ready SHALL be 0.
REQ-025 Once the block asserts result_valid, it SHALL NOT deassert it before result_ready is seen.
REQ-026 With no request_valid asserted, the block SHALL make no transfer and SHALL NOT change the arbitration state.

Reset
REQ-027 On reset the FSM SHALL enter EMPTY and result_valid SHALL be 0.
REQ-028 On reset result_data and result_id SHALL be 0, the round-robin pointer SHALL be 0, and request_ready SHALL be 0 during the reset cycle.
REQ-029 Reset asserted while FULL SHALL discard the held result without a handshake.

Configuration
REQ-030 With macro BARREL_SHIFTER_ARBITER_ROUND_ROBIN_EN defined, the block SHALL grant round-robin.
  - Search starts at the pointer; on each transfer the pointer becomes the granted index + 1, modulo REQUESTERS.
REQ-031 Without the macro, the block SHALL grant fixed priority (lowest valid index wins) and SHALL contain no pointer register.

Structure
REQ-032 Package barrel_shifter_arbiter_pkg SHALL hold the output FSM state enum (EMPTY, FULL).
REQ-033 The shift datapath SHALL be one instance of the existing barrel_shifter_right sub-module, fed by the granted requester's data, shift and pad_value.
  - It sits before the result register; no other shifting logic is permitted.

Verification (DATA_WIDTH=8, REQUESTERS=4)
REQ-034 Single request from requester 1 with data 0x80, shift 3, pad 0 → request_ready[1]=1 in that cycle; next cycle result_valid=1, result_data=0x10, result_id=1.
REQ-035 Requester 2 with data 0x0F, shift 2, pad 1 → result_data=0xC3; data 0x80, shift 7, pad 1 → 0xFF; shift 0 → data unchanged.
REQ-036 All four request_valid held high and result_ready=1 → one result per cycle.
  - With the macro: result_id sequence 0,1,2,3,0.
  - Without the macro: result_id 0 every cycle.
REQ-037 Backpressure: FULL with result_ready=0 for 5 cycles → result stable and request_ready=0 throughout.
  - Then result_ready=1 with requester 3 valid → drain and refill in the same cycle, result_id=3 next.
REQ-038 Reset asserted for one cycle while FULL with requesters valid → next cycle result_valid=0, result_data=0, result_id=0.
  - The first post-reset grant goes to requester 0 when all requesters are valid.
